sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_pkg.sv | 23 ++
 rtl/sram_arb_pick.sv | 20 ++
 rtl/sram_arbiter.sv | 146 ++++++++++++++
 tb/tb_sram_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_pkg;
  localparam int DW       = 16;
  localparam int AW_DEF   = 18;
  localparam int WAIT_DEF = 2;

  // All SRAM strobes are active low.
  localparam logic STB_OFF = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE
  } state_t;

  // Per-port request payload, excluding the address because its width is parameterized.
  typedef struct packed {
    logic          we;
    logic [1:0]    be;
    logic [DW-1:0] wdata;
  } xact_t;
endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner select between two requesters.
// SRAM_ARB_RR_EN selects round-robin; otherwise port 0 has fixed priority.
module sram_arb_pick (
  input  logic [1:0] req,
`ifdef SRAM_ARB_RR_EN
  input  logic       last,
`endif
  output logic       any,
  output logic       id
);
  always_comb begin
    any = |req;
`ifdef SRAM_ARB_RR_EN
    // On a tie, the port not served last goes first.
    id  = (&req) ? ~last : req[1];
`else
    id  = ~req[0];
`endif
  end
endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter for an asynchronous 16-bit SRAM with registered strobes.
// Define SRAM_ARB_RR_EN for round-robin arbitration instead of fixed priority.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_DEF,
  parameter int AW          = AW_DEF
) (
  input  logic          iClock,
  input  logic          iRst_n,
  input  logic          iAdaptor_en,
  input  logic          iReq0,
  input  logic          iReq1,
  input  logic          iWe0,
  input  logic          iWe1,
  input  logic [AW-1:0] iAddr0,
  input  logic [AW-1:0] iAddr1,
  input  logic [DW-1:0] iWdata0,
  input  logic [DW-1:0] iWdata1,
  input  logic [1:0]    iBe0,
  input  logic [1:0]    iBe1,
  output logic          oAck0,
  output logic          oAck1,
  output logic [DW-1:0] oRdata0,
  output logic [DW-1:0] oRdata1,
  output logic [AW-1:0] oSram_addr,
  output logic [DW-1:0] oSram_dq_out,
  output logic          oSram_dq_oe,
  input  logic [DW-1:0] iSram_dq_in,
  output logic          oSram_ce_n,
  output logic          oSram_oe_n,
  output logic          oSram_we_n,
  output logic          oSram_ub_n,
  output logic          oSram_lb_n
);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t        state;
  logic [3:0]    cnt;
  logic          cur_id;
  logic          cur_we;
  logic          pick_any;
  logic          pick_id;
  xact_t         sel;
  logic [AW-1:0] sel_addr;

`ifdef SRAM_ARB_RR_EN
  logic          last;
`endif

  sram_arb_pick u_pick (
    .req  ({iReq1, iReq0}),
`ifdef SRAM_ARB_RR_EN
    .last (last),
`endif
    .any  (pick_any),
    .id   (pick_id)
  );

  always_comb begin
    sel      = pick_id ? '{we: iWe1, be: iBe1, wdata: iWdata1}
                       : '{we: iWe0, be: iBe0, wdata: iWdata0};
    sel_addr = pick_id ? iAddr1 : iAddr0;
  end

  always_ff @(posedge iClock or negedge iRst_n) begin
    if (!iRst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      cur_id       <= 1'b0;
      cur_we       <= 1'b0;
      oAck0        <= 1'b0;
      oAck1        <= 1'b0;
      oRdata0      <= '0;
      oRdata1      <= '0;
      oSram_addr   <= '0;
      oSram_dq_out <= '0;
      oSram_dq_oe  <= 1'b0;
      oSram_ce_n   <= STB_OFF;
      oSram_oe_n   <= STB_OFF;
      oSram_we_n   <= STB_OFF;
      oSram_ub_n   <= STB_OFF;
      oSram_lb_n   <= STB_OFF;
`ifdef SRAM_ARB_RR_EN
      last         <= 1'b1;
`endif
    end else begin
      oAck0 <= 1'b0;
      oAck1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (iAdaptor_en && pick_any) begin
            // Outputs for SETUP are loaded on the granting edge so they appear in SETUP itself.
            state       <= ST_SETUP;
            cur_id      <= pick_id;
            cur_we      <= sel.we;
            oSram_addr  <= sel_addr;
            oSram_ce_n  <= 1'b0;
            oSram_ub_n  <= sel.we ? ~sel.be[1] : 1'b0;
            oSram_lb_n  <= sel.we ? ~sel.be[0] : 1'b0;
            oSram_dq_oe <= sel.we;
            if (sel.we) oSram_dq_out <= sel.wdata;
`ifdef SRAM_ARB_RR_EN
            last        <= pick_id;
`endif
          end
        end
        ST_SETUP: begin
          state      <= ST_ACCESS;
          cnt        <= CNT_INIT;
          oSram_we_n <= ~cur_we;
          oSram_oe_n <= cur_we;
        end
        ST_ACCESS: begin
          if (cnt == 4'd0) begin
            state      <= ST_DONE;
            oSram_we_n <= STB_OFF;
            oSram_oe_n <= STB_OFF;
            if (cur_id) oAck1 <= 1'b1;
            else        oAck0 <= 1'b1;
            if (!cur_we) begin
              if (cur_id) oRdata1 <= iSram_dq_in;
              else        oRdata0 <= iSram_dq_in;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_DONE: begin
          // Address and write data stay put through DONE for SRAM hold time.
          state       <= ST_IDLE;
          oSram_ce_n  <= STB_OFF;
          oSram_ub_n  <= STB_OFF;
          oSram_lb_n  <= STB_OFF;
          oSram_dq_oe <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  a_no_we_oe: assert property (@(posedge iClock) disable iff (!iRst_n)
    !(!oSram_we_n && !oSram_oe_n));
  a_no_drive_rd: assert property (@(posedge iClock) disable iff (!iRst_n)
    !(oSram_dq_oe && !oSram_oe_n));
endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter against a transaction-level model and an SRAM array model.
module tb_sram_arbiter;
  localparam int W  = 2;
  localparam int AW = 18;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                en = 1'b0;
  logic [1:0]          req = '0;
  logic [1:0]          we = '0;
  logic [1:0][AW-1:0]  addr = '0;
  logic [1:0][15:0]    wd = '0;
  logic [1:0][1:0]     be = '0;
  logic                ack0, ack1;
  logic [15:0]         rdata0, rdata1;
  logic [AW-1:0]       sram_addr;
  logic [15:0]         dq_out, dq_in;
  logic                dq_oe, ce_n, oe_n, we_n, ub_n, lb_n;

  sram_arbiter #(.WAIT_CYCLES(W), .AW(AW)) dut (
    .iClock(clk), .iRst_n(rst_n), .iAdaptor_en(en),
    .iReq0(req[0]), .iReq1(req[1]), .iWe0(we[0]), .iWe1(we[1]),
    .iAddr0(addr[0]), .iAddr1(addr[1]), .iWdata0(wd[0]), .iWdata1(wd[1]),
    .iBe0(be[0]), .iBe1(be[1]), .oAck0(ack0), .oAck1(ack1),
    .oRdata0(rdata0), .oRdata1(rdata1), .oSram_addr(sram_addr),
    .oSram_dq_out(dq_out), .oSram_dq_oe(dq_oe), .iSram_dq_in(dq_in),
    .oSram_ce_n(ce_n), .oSram_oe_n(oe_n), .oSram_we_n(we_n),
    .oSram_ub_n(ub_n), .oSram_lb_n(lb_n)
  );

  always #5 clk = ~clk;

  // Physical SRAM: responds to whatever strobes the DUT drives.
  bit [15:0] mem [256];
  always @(posedge clk) begin
    if (!ce_n && !we_n) begin
      if (!ub_n) mem[sram_addr[7:0]][15:8] <= dq_out[15:8];
      if (!lb_n) mem[sram_addr[7:0]][7:0]  <= dq_out[7:0];
    end
  end
  always_comb dq_in = (!ce_n && !oe_n) ? mem[sram_addr[7:0]] : 16'hBEEF;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Transaction-level reference state.
  bit [15:0]     ref_mem [256];
  int            cyc = 0;
  int            grant_cyc = -100;
  int            next_free = 0;
  logic          last_g = 1'b1;
  logic          t_id, t_we;
  logic [AW-1:0] t_addr;
  logic [15:0]   t_wd, t_rexp;
  logic [1:0]    t_be;
  logic [15:0]   exp_rd [2];
  int            nack [2];
  int            ack_cyc [2];
  int            wel = 0, oel = 0, dqoe_cnt = 0, ce_cnt = 0;

  task automatic monitor();
    int   ph;
    logic act, acc, done;
    if (!rst_n) begin
      chk("rst_ce", ce_n, 1); chk("rst_oe", oe_n, 1); chk("rst_we", we_n, 1);
      chk("rst_ub", ub_n, 1); chk("rst_lb", lb_n, 1); chk("rst_dqoe", dq_oe, 0);
      chk("rst_ack", {ack1, ack0}, 0); chk("rst_rd0", rdata0, 0); chk("rst_rd1", rdata1, 0);
      chk("rst_addr", sram_addr, 0); chk("rst_dqout", dq_out, 0);
      grant_cyc = -100; next_free = 0; last_g = 1'b1;
      exp_rd[0] = '0; exp_rd[1] = '0;
      cyc++;
      return;
    end
    ph   = cyc - grant_cyc;
    act  = (grant_cyc >= 0) && (ph >= 1) && (ph <= W + 2);
    acc  = act && (ph >= 2) && (ph <= W + 1);
    done = act && (ph == W + 2);
    chk("ce_n", ce_n, !act);
    chk("we_n", we_n, !(acc && t_we));
    chk("oe_n", oe_n, !(acc && !t_we));
    chk("dq_oe", dq_oe, act && t_we);
    chk("ub_n", ub_n, act ? (t_we ? !t_be[1] : 1'b0) : 1'b1);
    chk("lb_n", lb_n, act ? (t_we ? !t_be[0] : 1'b0) : 1'b1);
    if (act) chk("addr", sram_addr, t_addr);
    if (act && t_we) chk("dq_out", dq_out, t_wd);
    if (done && !t_we) exp_rd[t_id] = t_rexp;
    chk("ack0", ack0, done && !t_id);
    chk("ack1", ack1, done && t_id);
    chk("rdata0", rdata0, exp_rd[0]);
    chk("rdata1", rdata1, exp_rd[1]);
    if (!we_n) wel++;
    if (!oe_n) oel++;
    if (dq_oe) dqoe_cnt++;
    if (!ce_n) ce_cnt++;
    if (ack0) begin nack[0]++; ack_cyc[0] = cyc; end
    if (ack1) begin nack[1]++; ack_cyc[1] = cyc; end
    if (cyc >= next_free && en && (|req)) begin
`ifdef SRAM_ARB_RR_EN
      t_id = (&req) ? !last_g : req[1];
`else
      t_id = !req[0];
`endif
      t_we = we[t_id]; t_addr = addr[t_id]; t_wd = wd[t_id]; t_be = be[t_id];
      t_rexp = ref_mem[t_addr[7:0]];
      if (t_we) begin
        if (t_be[1]) ref_mem[t_addr[7:0]][15:8] = t_wd[15:8];
        if (t_be[0]) ref_mem[t_addr[7:0]][7:0]  = t_wd[7:0];
      end
      grant_cyc = cyc;
      next_free = cyc + W + 3;
      last_g    = t_id;
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_fields(input int p);
    we[p]   = 1'($urandom);
    addr[p] = AW'($urandom % 32);
    wd[p]   = 16'($urandom);
    be[p]   = 2'($urandom);
  endtask

  task automatic wait_ack(input int p, input int k, output int lat);
    int  n0 = nack[p];
    bit  got = 0;
    for (int i = 0; i < 80 && !got; i++) begin
      step();
      if (nack[p] != n0) got = 1;
    end
    if (!got) chk("ack_timeout", 0, 1);
    lat = ack_cyc[p] - k;
  endtask

  task automatic issue(input int p, input logic w, input logic [AW-1:0] a,
                       input logic [15:0] d, input logic [1:0] b, output int lat);
    int k;
    we[p] = w; addr[p] = a; wd[p] = d; be[p] = b; req[p] = 1'b1;
    k = cyc;
    wait_ack(p, k, lat);
    req[p] = 1'b0;
  endtask

  initial begin
    int lat, n0, n1, d0, d1, k;
    int seen [2];
    nack[0] = 0; nack[1] = 0; ack_cyc[0] = 0; ack_cyc[1] = 0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b1;
    en = 1'b1;
    step();

    wel = 0;
    issue(0, 1'b1, AW'('h10), 16'hA55A, 2'b11, lat);
    chk("wr_latency", lat, W + 2);
    chk("wr_we_low", wel, W);
    chk("wr_no_ack1", nack[1], 0);

    oel = 0; dqoe_cnt = 0;
    issue(1, 1'b0, AW'('h10), 16'h0000, 2'b00, lat);
    chk("rd_data", rdata1, 16'hA55A);
    chk("rd_latency", lat, W + 2);
    chk("rd_oe_low", oel, W);
    chk("rd_no_dqoe", dqoe_cnt, 0);

    issue(0, 1'b1, AW'('h10), 16'h1234, 2'b01, lat);
    issue(1, 1'b0, AW'('h10), 16'h0000, 2'b00, lat);
    chk("be_lower_only", rdata1, 16'hA534);

    en = 1'b0; ce_cnt = 0; n0 = nack[0];
    we[0] = 1'b1; addr[0] = AW'('h20); wd[0] = 16'h5555; be[0] = 2'b11; req[0] = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("en_off_ack", nack[0], n0);
    chk("en_off_ce", ce_cnt, 0);
    en = 1'b1; k = cyc;
    wait_ack(0, k, lat);
    req[0] = 1'b0;
    chk("en_on_latency", lat, W + 2);

    we[0] = 1'b0; addr[0] = AW'('h10); req[0] = 1'b1;
    n0 = nack[0];
    step(); step(); step();
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ce", ce_n, 1); chk("abort_oe", oe_n, 1); chk("abort_ack", ack0, 0);
    step(); step();
    chk("abort_no_ack", nack[0], n0);
    rst_n = 1'b1; k = cyc;
    wait_ack(0, k, lat);
    req[0] = 1'b0;
    chk("regrant_latency", lat, W + 2);
    chk("regrant_data", rdata0, 16'hA534);

    seen[0] = nack[0]; seen[1] = nack[1];
    for (int n = 0; n < 2500; n++) begin
      step();
      en = ($urandom % 10) != 0;
      for (int p = 0; p < 2; p++) begin
        if (req[p]) begin
          if (nack[p] != seen[p]) begin
            seen[p] = nack[p];
            if ($urandom % 2 == 0) rand_fields(p);
            else req[p] = 1'b0;
          end else if ($urandom % 8 == 0) rand_fields(p);
        end else if ($urandom % 4 == 0) begin
          rand_fields(p);
          req[p] = 1'b1;
        end
      end
    end

    req = '0; en = 1'b1;
    for (int i = 0; i < 15; i++) step();
    n0 = nack[0]; n1 = nack[1];
    seen[0] = nack[0]; seen[1] = nack[1];
    rand_fields(0); rand_fields(1); req = 2'b11;
    for (int n = 0; n < 60; n++) begin
      step();
      for (int p = 0; p < 2; p++)
        if (nack[p] != seen[p]) begin seen[p] = nack[p]; rand_fields(p); end
    end
    req = '0;
    d0 = nack[0] - n0; d1 = nack[1] - n1;
`ifdef SRAM_ARB_RR_EN
    chk("rr_balance", ((d0 - d1) <= 1 && (d1 - d0) <= 1 && d0 >= 5), 1);
`else
    chk("starve_p1", d1, 0);
    chk("cont_p0", d0 >= 11, 1);
`endif
    for (int i = 0; i < 10; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
